mips_mc_control: RTL and testbench
==================================

# mips_mc_control

Multi-cycle control sequencer for the MIPS datapath. It decodes the instruction held in the instruction register and steps the datapath through fetch, decode, execute, memory and writeback. It drives the register file's `regwrite`/`alusrc` pair, the ALU operand and PC muxes, and a request/acknowledge handshake to unified memory. It also counts retired instructions.

## Interface
- `OP_RTYPE`, 6'b000000, R-type opcode
- `OP_LW`, 6'b100011, load word
- `OP_SW`, 6'b101011, store word
- `OP_BEQ`, 6'b000100, branch on equal
- `OP_ADDI`, 6'b001000, add immediate
- `OP_J`, 6'b000010, jump

Ports:
- `clk`  in  1  single clock; all state on posedge
- `reset`  in  1  synchronous, active-high
- `instdata`  in  32  instruction register contents; opcode in [31:26]
- `mem_ack`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  write qualifier for `mem_req`
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `irwrite`  out  1  load the instruction register
- `pcwrite`  out  1  unconditional PC load
- `pcwritecond`  out  1  PC load qualified by ALU zero
- `pcsource`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- `alusrca`  out  1  ALU A operand: 0 = PC, 1 = rs data
- `alusrcb`  out  2  ALU B operand: 00 = rt data, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- `aluop`  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct
- `memtoreg`  out  1  writeback source: 0 = ALUOut, 1 = memory data
- `regwrite`  out  1  register file write enable
- `alusrc`  out  1  register file destination select: 0 = rd, 1 = rt
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode
- `retire`  out  1  one-cycle pulse on the final cycle of each legal instruction
- `instr_count`  out  32  count of retired instructions
- `state`  out  4  current state encoding, for debug

## Operation
States and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- RTEXEC=6, RTWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11
- Encodings 12–15 are unreachable; if entered, the next state is FETCH.

Per-state outputs and transitions. Every output not listed for a state is 0.
- **FETCH**
  - Outputs: `mem_req`=1, `iord`=0, `alusrcb`=01, `aluop`=00, `pcsource`=00.
  - On `mem_ack`: `irwrite`=1 and `pcwrite`=1 in the same cycle, then go to DECODE.
  - Without `mem_ack`: hold FETCH.
- **DECODE**
  - Outputs: `alusrcb`=11, `aluop`=00.
  - Next state by opcode:
    - R-type → RTEXEC
    - lw, sw → MEMADR
    - beq → BRANCH
    - addi → IEXEC
    - j → JUMP
    - any other opcode → FETCH, with `illegal_op`=1 this cycle
- **MEMADR** and **IEXEC**
  - Outputs: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - MEMADR: lw → MEMRD, sw → MEMWR.
  - IEXEC → IWB.
- **MEMRD**
  - Outputs: `mem_req`=1, `iord`=1.
  - On `mem_ack` → MEMWB; otherwise hold.
- **MEMWR**
  - Outputs: `mem_req`=1, `mem_we`=1, `iord`=1.
  - On `mem_ack`: `retire`=1, then FETCH; otherwise hold.
- **MEMWB**
  - Outputs: `regwrite`=1, `alusrc`=1, `memtoreg`=1, `retire`=1.
  - Next: FETCH.
- **RTEXEC**
  - Outputs: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - Next: RTWB.
- **RTWB**
  - Outputs: `regwrite`=1, `alusrc`=0, `memtoreg`=0, `retire`=1.
  - Next: FETCH.
- **IWB**
  - Outputs: `regwrite`=1, `alusrc`=1, `memtoreg`=0, `retire`=1.
  - Next: FETCH.
- **BRANCH**
  - Outputs: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcwritecond`=1, `pcsource`=01, `retire`=1.
  - Next: FETCH.
- **JUMP**
  - Outputs: `pcwrite`=1, `pcsource`=10, `retire`=1.
  - Next: FETCH.

Instruction counter:
- `instr_count` increments by 1 on every clock edge where `retire`=1.
- It wraps from 32'hFFFFFFFF to 0.

Memory handshake rules:
- `mem_ack` is ignored when `mem_req`=0.
- `mem_req` remains asserted, with `iord`/`mem_we` stable, until `mem_ack` is seen.

## Timing
Outputs:
- All outputs are decoded from `state`.
- Exceptions decoded from the inputs as well:
  - `irwrite` and `pcwrite` in FETCH, and `retire` in MEMWR, are additionally gated by `mem_ack`.
  - `illegal_op` is additionally gated by the opcode.

Reset:
- While `reset`=1, every output is forced to 0, including `mem_req`, `mem_we` and `regwrite`.
- At the first posedge with `reset`=1: `state`←FETCH and `instr_count`←0.
- The first cycle after reset deasserts shows `mem_req`=1, `iord`=0.
- Reset asserted mid-instruction, including during a MEMWR wait, aborts the instruction with no write, no retire and no PC update.

Latency (cycles from FETCH entry to `retire`, with `mem_ack` returned in the first request cycle):
- beq and j: 3
- R-type, addi and sw: 4
- lw: 5
- Each extra wait cycle on a memory access adds 1.

Register-file write:
- The register-file write occurs on the posedge ending the RTWB, IWB or MEMWB cycle.

## Test plan
- **Reset:** hold `reset` 3 cycles with `mem_ack`=1.
  - All outputs stay 0 and `instr_count`=0.
  - After release, `state`=0 and `mem_req`=1.
- **R-type add** (`instdata`=32'h012A4020), `mem_ack` tied 1.
  - States 0→1→6→7→0.
  - In RTWB: `regwrite`=1, `alusrc`=0.
  - `instr_count`=1.
- **lw** (32'h8D280004) with `mem_ack` delayed 2 cycles on the data read.
  - MEMRD is held 3 cycles with `iord`=1.
  - MEMWB has `regwrite`=1, `alusrc`=1, `memtoreg`=1.
  - Total 7 cycles.
- **sw, then reset** asserted during MEMWR before `mem_ack`.
  - `mem_we` drops to 0 in the reset cycle.
  - `state` returns to 0 and `instr_count` is unchanged at 0.
- **Illegal and beq**
  - Opcode 6'b111111: `illegal_op` pulses in DECODE, no retire, back to FETCH.
  - beq: 3 cycles, `pcwritecond`=1 and `aluop`=01 in BRANCH.
- **Counter wrap:** preload via 2^32−1 retirements (force), then one j.
  - `instr_count` = 0.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control sequencer. It decodes the opcode in the instruction
// register and walks the datapath through fetch, decode, execute, memory and
// writeback. It handshakes with unified memory over mem_req/mem_ack and counts
// retired instructions.
module mips_mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pcwritecond,
  output logic [1:0]  pcsource,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrc,
  output logic        illegal_op,
  output logic        retire,
  output logic [31:0] instr_count,
  output logic [3:0]  state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] count_q;
  logic [5:0]  opcode;
  logic        unused_bits;

  assign opcode      = instdata[31:26];
  assign unused_bits = ^instdata[25:0];

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; memory states hold until the access is acknowledged.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = mem_ack ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = RTEXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = IEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ack ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ack ? FETCH : MEMWR;
      MEMWB:  state_d = FETCH;
      RTEXEC: state_d = RTWB;
      RTWB:   state_d = FETCH;
      BRANCH: state_d = FETCH;
      IEXEC:  state_d = IWB;
      IWB:    state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output decode from the current state; reset forces every output low.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsource    = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrc      = 1'b0;
    illegal_op  = 1'b0;
    retire      = 1'b0;
    instr_count = 32'd0;
    state       = 4'd0;
    if (!reset) begin
      instr_count = count_q;
      state       = state_q;
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ack;
          pcwrite = mem_ack;
        end
        DECODE: begin
          alusrcb = 2'b11;
          case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
            default: illegal_op = 1'b1;
          endcase
        end
        MEMADR, IEXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          retire  = mem_ack;
        end
        MEMWB: begin
          regwrite = 1'b1;
          alusrc   = 1'b1;
          memtoreg = 1'b1;
          retire   = 1'b1;
        end
        RTEXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        RTWB: begin
          regwrite = 1'b1;
          retire   = 1'b1;
        end
        IWB: begin
          regwrite = 1'b1;
          alusrc   = 1'b1;
          retire   = 1'b1;
        end
        BRANCH: begin
          alusrca     = 1'b1;
          aluop       = 2'b01;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
          retire      = 1'b1;
        end
        JUMP: begin
          pcwrite  = 1'b1;
          pcsource = 2'b10;
          retire   = 1'b1;
        end
        default: begin
          state = state_q;
        end
      endcase
    end
  end

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset)       count_q <= 32'd0;
    else if (retire) count_q <= count_q + 32'd1;
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control. Each step drives inputs on the falling
// edge, pushes the expected outputs to a scoreboard, and compares them against
// the DUT shortly afterwards.
module tb_mips_mc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instdata;
  logic        mem_ack;
  logic        mem_req, mem_we, iord, irwrite, pcwrite, pcwritecond;
  logic [1:0]  pcsource, alusrcb, aluop;
  logic        alusrca, memtoreg, regwrite, alusrc, illegal_op, retire;
  logic [31:0] instr_count;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [21:0] vec;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] I_RTYPE = 32'h012A4020;
  localparam logic [31:0] I_LW    = 32'h8D280004;
  localparam logic [31:0] I_SW    = 32'hAD280004;
  localparam logic [31:0] I_ILL   = 32'hFC000000;
  localparam logic [31:0] I_BEQ   = 32'h11090003;
  localparam logic [31:0] I_ADDI  = 32'h21090005;
  localparam logic [31:0] I_J     = 32'h08000010;

  mips_mc_control dut (
    .clk(clk), .reset(reset), .instdata(instdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcsource(pcsource),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrc(alusrc), .illegal_op(illegal_op),
    .retire(retire), .instr_count(instr_count), .state(state)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference control table: expected outputs for a state, ack and opcode.
  function automatic logic [21:0] ctl(input logic [3:0] st, input logic ack, input logic [5:0] op);
    logic mr, mw, io, irw, pcw, pcc, asa, mtr, rw, asr, ill, ret;
    logic [1:0] pcs, asb, aop;
    {mr, mw, io, irw, pcw, pcc, asa, mtr, rw, asr, ill, ret} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mr = 1; asb = 2'b01; irw = ack; pcw = ack; end
      4'd1:  begin
        asb = 2'b11;
        ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
      end
      4'd2, 4'd9: begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; io = 1; end
      4'd4:  begin rw = 1; asr = 1; mtr = 1; ret = 1; end
      4'd5:  begin mr = 1; mw = 1; io = 1; ret = ack; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; ret = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; ret = 1; end
      4'd10: begin rw = 1; asr = 1; ret = 1; end
      4'd11: begin pcw = 1; pcs = 2'b10; ret = 1; end
      default: ;
    endcase
    return {mr, mw, io, irw, pcw, pcc, pcs, asa, asb, aop, mtr, rw, asr, ill, ret, st};
  endfunction

  // Pop the oldest expectation and compare it to the live DUT outputs.
  task automatic checkOutput();
    exp_t e;
    logic [21:0] obs;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      obs = {mem_req, mem_we, iord, irwrite, pcwrite, pcwritecond, pcsource,
             alusrca, alusrcb, aluop, memtoreg, regwrite, alusrc, illegal_op,
             retire, state};
      assert (obs === e.vec) else begin
        errors++;
        $error("[TB] FAIL %s_ctl: observed %h expected %h", e.tag, obs, e.vec);
      end
      checks++;
      assert (instr_count === e.cnt) else begin
        errors++;
        $error("[TB] FAIL %s_count: observed %h expected %h", e.tag, instr_count, e.cnt);
      end
    end
  endtask

  // Drive one cycle of inputs, record what the DUT should show, then check.
  task automatic applyStimulus(input logic rst, input logic [31:0] instr, input logic ack,
                               input logic [3:0] st, input logic [31:0] cnt, input string tag);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    instdata = instr;
    mem_ack  = ack;
    e.tag = tag;
    e.vec = rst ? 22'd0 : ctl(st, ack, instr[31:26]);
    e.cnt = rst ? 32'd0 : cnt;
    sb.push_back(e);
    #1 checkOutput();
  endtask

  // Directed sequence covering reset, each instruction class and counter wrap.
  initial begin
    reset = 1'b1; instdata = 32'd0; mem_ack = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(1, 32'd0, 1, 4'd0, 0, "reset");

    applyStimulus(0, I_RTYPE, 1, 4'd0, 0, "rt_fetch");
    applyStimulus(0, I_RTYPE, 1, 4'd1, 0, "rt_decode");
    applyStimulus(0, I_RTYPE, 1, 4'd6, 0, "rt_exec");
    applyStimulus(0, I_RTYPE, 1, 4'd7, 0, "rt_wb");

    applyStimulus(0, I_LW, 1, 4'd0, 1, "lw_fetch");
    applyStimulus(0, I_LW, 1, 4'd1, 1, "lw_decode");
    applyStimulus(0, I_LW, 1, 4'd2, 1, "lw_memadr");
    applyStimulus(0, I_LW, 0, 4'd3, 1, "lw_memrd_wait1");
    applyStimulus(0, I_LW, 0, 4'd3, 1, "lw_memrd_wait2");
    applyStimulus(0, I_LW, 1, 4'd3, 1, "lw_memrd_ack");
    applyStimulus(0, I_LW, 1, 4'd4, 1, "lw_memwb");

    applyStimulus(0, I_SW, 1, 4'd0, 2, "sw_fetch");
    applyStimulus(0, I_SW, 1, 4'd1, 2, "sw_decode");
    applyStimulus(0, I_SW, 1, 4'd2, 2, "sw_memadr");
    applyStimulus(0, I_SW, 0, 4'd5, 2, "sw_memwr_wait1");
    applyStimulus(0, I_SW, 0, 4'd5, 2, "sw_memwr_wait2");
    applyStimulus(1, I_SW, 0, 4'd0, 0, "sw_abort_reset");

    applyStimulus(0, I_ILL, 1, 4'd0, 0, "ill_fetch");
    applyStimulus(0, I_ILL, 1, 4'd1, 0, "ill_decode");

    applyStimulus(0, I_BEQ, 1, 4'd0, 0, "beq_fetch");
    applyStimulus(0, I_BEQ, 1, 4'd1, 0, "beq_decode");
    applyStimulus(0, I_BEQ, 1, 4'd8, 0, "beq_branch");

    applyStimulus(0, I_ADDI, 1, 4'd0, 1, "addi_fetch");
    applyStimulus(0, I_ADDI, 0, 4'd1, 1, "addi_decode");
    applyStimulus(0, I_ADDI, 1, 4'd9, 1, "addi_exec");
    applyStimulus(0, I_ADDI, 1, 4'd10, 1, "addi_wb");

    applyStimulus(0, I_J, 0, 4'd0, 2, "j_fetch_wait");
    applyStimulus(0, I_J, 1, 4'd0, 2, "j_fetch");
    applyStimulus(0, I_J, 1, 4'd1, 2, "j_decode");
    applyStimulus(0, I_J, 1, 4'd11, 2, "j_jump");
    applyStimulus(0, I_J, 0, 4'd0, 3, "j_done");

    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    applyStimulus(0, I_J, 0, 4'd0, 32'hFFFF_FFFF, "wrap_preload");
    applyStimulus(0, I_J, 1, 4'd0, 32'hFFFF_FFFF, "wrap_fetch");
    applyStimulus(0, I_J, 1, 4'd1, 32'hFFFF_FFFF, "wrap_decode");
    applyStimulus(0, I_J, 1, 4'd11, 32'hFFFF_FFFF, "wrap_jump");
    applyStimulus(0, I_J, 0, 4'd0, 32'd0, "wrap_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
